// File: rtl/input_feeder.sv
// Tile input feeder: buffers DEPTH vectors, streams them to the skew shifters, then
// issues ROWS zero beats so the diagonal drains before the next tile is accepted.
module input_feeder #(
   parameter int unsigned ROWS       = 4,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_WIDTH*ROWS-1:0] in_data,
   input  logic                       stall,
   output logic [DATA_WIDTH*ROWS-1:0] out_data,
   output logic                       out_enable,
   output logic                       out_last,
   output logic                       busy,
   output logic                       done
);

   localparam int unsigned VecW = DATA_WIDTH * ROWS;
   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);
   localparam logic [CntW-1:0] CntLast = CntW'(ROWS - 1);

   typedef enum logic [1:0] {StLoad, StStream, StFlush} state_e;

   state_e            state_q, state_d;
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   flush_cnt_q, flush_cnt_d;
   logic [VecW-1:0]   out_data_q, out_data_d;
   logic              out_enable_q, out_enable_d;
   logic              out_last_q, out_last_d;
   logic              done_q, done_d;
   logic [VecW-1:0]   buf_q [DEPTH];
   logic              accept;

   assign in_ready   = (state_q == StLoad) && !rst;
   assign accept     = in_valid && in_ready;
   assign busy       = (state_q != StLoad);
   assign out_data   = out_data_q;
   assign out_enable = out_enable_q;
   assign out_last   = out_last_q;
   assign done       = done_q;

   // Buffer is only written while loading, so it stays stable through STREAM/FLUSH.
   always_ff @(posedge clk) begin
      if (accept) begin
         buf_q[wr_ptr_q] <= in_data;
      end
   end

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      flush_cnt_d  = flush_cnt_q;
      out_data_d   = out_data_q;
      out_enable_d = 1'b0;
      out_last_d   = 1'b0;
      done_d       = 1'b0;
      unique case (state_q)
         StLoad: begin
            out_data_d = '0;
            if (accept) begin
               if (wr_ptr_q == PtrLast) begin
                  wr_ptr_d = '0;
                  state_d  = StStream;
               end else begin
                  wr_ptr_d = wr_ptr_q + PtrW'(1);
               end
            end
         end
         StStream: begin
            if (!stall) begin
               out_data_d   = buf_q[rd_ptr_q];
               out_enable_d = 1'b1;
               out_last_d   = (rd_ptr_q == PtrLast);
               if (rd_ptr_q == PtrLast) begin
                  rd_ptr_d = '0;
                  state_d  = StFlush;
               end else begin
                  rd_ptr_d = rd_ptr_q + PtrW'(1);
               end
            end
         end
         StFlush: begin
            if (!stall) begin
               out_data_d   = '0;
               out_enable_d = 1'b1;
               if (flush_cnt_q == CntLast) begin
                  flush_cnt_d = '0;
                  done_d      = 1'b1;
                  state_d     = StLoad;
               end else begin
                  flush_cnt_d = flush_cnt_q + CntW'(1);
               end
            end
         end
         default: state_d = StLoad;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StLoad;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         flush_cnt_q  <= '0;
         out_data_q   <= '0;
         out_enable_q <= 1'b0;
         out_last_q   <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         flush_cnt_q  <= flush_cnt_d;
         out_data_q   <= out_data_d;
         out_enable_q <= out_enable_d;
         out_last_q   <= out_last_d;
         done_q       <= done_d;
      end
   end

endmodule
